vending_controller: RTL and testbench
=====================================

VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
  NUM_DRINKS, 2, number of selectable drinks
  CREDIT_W, 6, width of credit/price/change fields
  PRICES, {6'd9,6'd7}, packed prices, drink i at bits [i*CREDIT_W +: CREDIT_W]; default drink0=tea Rs7, drink1=coffee Rs9
  MAX_CREDIT, 50, highest credit accepted
  TIMEOUT, 1000, idle cycles in COLLECT before auto-refund
  SEL_W, 1, width of drink index (>= clog2(NUM_DRINKS))
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  rising-edge clock
  rst  input  1  asynchronous active-low reset
  enable  input  1  sales enabled; when low, coins and selections are refused
  coin_valid  input  1  one-cycle coin-inserted strobe
  coin_val  input  4  coin value in rupees (1..15; 0 treated as invalid)
  sel_valid  input  1  one-cycle selection strobe
  sel_drink  input  SEL_W  selected drink index
  cancel  input  1  one-cycle refund request
  credit  output  CREDIT_W  current accumulated credit
  coin_reject  output  1  one-cycle pulse: the coin was not accepted
  sel_short  output  1  one-cycle pulse: credit is below price, or index >= NUM_DRINKS
  dispense_valid  output  1  one-cycle dispense pulse
  dispense_drink  output  SEL_W  drink index; valid with dispense_valid
  change_valid  output  1  one-cycle change pulse
  change_amt  output  CREDIT_W  change in rupees; valid with change_valid
  busy  output  1  high in DISPENSE or REFUND

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have the states IDLE (credit=0), COLLECT (credit>0), DISPENSE and REFUND.
REQ-006 Input priority within one cycle SHALL be cancel > sel_valid > coin_valid, evaluated in IDLE and COLLECT only.
  A coin arriving in the same cycle as an accepted cancel or selection is refused (coin_reject=1).
REQ-007 A coin SHALL be accepted when all of the following hold:
  enable=1
  state is IDLE or COLLECT
  coin_val != 0
  credit+coin_val <= MAX_CREDIT
  On acceptance, credit is updated next cycle and the FSM goes to COLLECT.
  Otherwise coin_reject pulses next cycle and credit is unchanged.
REQ-008 Any coin in DISPENSE or REFUND SHALL be refused (coin_reject=1).
REQ-009 A selection in COLLECT with enable=1, a valid index and credit >= PRICES[sel_drink] SHALL move the FSM to DISPENSE.
  Dispense timing: dispense_valid=1 and dispense_drink=sel on the next cycle.
  Change is captured as credit-price.
REQ-010 A selection with insufficient credit or an invalid index SHALL pulse sel_short next cycle, with state and credit unchanged.
  Selections in IDLE, or with enable=0, are ignored with no pulse.
REQ-011 From DISPENSE, the FSM SHALL go to REFUND if the captured change > 0, otherwise to IDLE.
  DISPENSE lasts exactly one cycle.
  credit reads 0 from the DISPENSE cycle onward.
REQ-012 REFUND SHALL last one cycle: change_valid=1 and change_amt=the refund value, then IDLE.
REQ-013 Latency SHALL be as follows:
  selection-to-dispense: 1 cycle
  selection-to-change: 2 cycles
  cancel-to-change: 1 cycle
REQ-014 cancel in COLLECT SHALL go to REFUND with change_amt=credit, regardless of enable.
  cancel in IDLE, DISPENSE or REFUND is ignored.
REQ-015 The idle counter SHALL clear on entering COLLECT and on every accepted coin or sel_short event.
  When TIMEOUT cycles elapse in COLLECT with no such event, the FSM auto-refunds exactly as for cancel.
REQ-016 When enable falls in COLLECT, credit SHALL be retained, and cancel and the timeout refund remain active.
REQ-017 Pulse outputs SHALL be high for exactly one cycle per event.
  change_amt and dispense_drink read 0 when their valid is low.

Reset
REQ-018 Asserting rst=0 SHALL asynchronously force the following:
  state=IDLE, credit=0
  all pulse outputs=0, busy=0
  dispense_drink=0, change_amt=0
  idle counter=0
REQ-019 Reset mid-DISPENSE or mid-REFUND SHALL abort the transaction, with no pulse emitted after reset.
  Credit is lost by design.

Verification
REQ-020 Tea, exact coins: coins 5,2 then sel 0 -> credit 5 then 7, dispense_valid with drink 0 one cycle after sel, no change_valid, IDLE.
REQ-021 Coffee with change: coins 10 then sel 1 -> dispense drink 1, next cycle change_valid with change_amt=1, then IDLE.
REQ-022 Short credit and cancel: coin 5, sel 1 -> sel_short=1, credit stays 5; then cancel -> change_amt=5 one cycle later.
REQ-023 Overflow, conflict and enable checks:
  coins totalling 48, then coin 5 -> coin_reject, credit 48
  coin and sel same cycle (credit 10, sel 0) -> dispense, coin_reject, change 3
  enable=0 with coin 2 -> coin_reject
REQ-024 Timeout: TIMEOUT=8, coin 2, then idle -> change_valid with change_amt=2 exactly 8 cycles after the coin's credit update.
REQ-025 Async reset during DISPENSE -> all outputs 0 immediately, no change pulse afterwards.

Source files
------------

// File: rtl/vending_controller.sv
// Vending controller: accumulates coin credit, validates drink selections
// against packed prices, sequences dispense and change, and refunds credit
// on cancel or after an idle timeout. Every output is driven from a register.
module vending_controller #(
    parameter int                             NUM_DRINKS = 2,
    parameter int                             CREDIT_W   = 6,
    parameter logic [NUM_DRINKS*CREDIT_W-1:0] PRICES     = {6'd9, 6'd7},
    parameter int                             MAX_CREDIT = 50,
    parameter int                             TIMEOUT    = 1000,
    parameter int                             SEL_W      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                coin_valid,
    input  logic [3:0]          coin_val,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_drink,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_short,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_drink,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                busy
);

    // One extra bit so that credit + coin can never wrap before the limit test.
    localparam int SUM_W = CREDIT_W + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(MAX_CREDIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_REFUND   = 2'd3
    } state_t;

    // Registered state and outputs
    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_change;
    logic [CNT_W-1:0]    r_idle_cnt;
    logic                r_coin_reject;
    logic                r_sel_short;
    logic                r_dispense_valid;
    logic [SEL_W-1:0]    r_dispense_drink;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_amt;
    logic                r_busy;

    // Next-state values
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_change_nxt;
    logic [CNT_W-1:0]    w_idle_cnt_nxt;
    logic                w_coin_reject_nxt;
    logic                w_sel_short_nxt;
    logic                w_dispense_valid_nxt;
    logic [SEL_W-1:0]    w_dispense_drink_nxt;
    logic                w_change_valid_nxt;
    logic [CREDIT_W-1:0] w_change_amt_nxt;
    logic                w_busy_nxt;

    // Input qualification
    logic                w_cancel_take;
    logic                w_sel_idx_ok;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_live;
    logic                w_sel_take;
    logic                w_sel_short;
    logic [SUM_W-1:0]    w_sum;
    logic                w_coin_take;
    logic                w_timeout;

    // Decode cancel > selection > coin priority and the idle timeout.
    always_comb begin
        w_cancel_take = cancel && (r_state == S_COLLECT);
        w_sel_idx_ok  = (int'(sel_drink) < NUM_DRINKS);
        w_price       = w_sel_idx_ok ? PRICES[int'(sel_drink)*CREDIT_W +: CREDIT_W] : '0;
        // Selections only count while collecting, enabled and not overridden by cancel.
        w_sel_live    = sel_valid && enable && (r_state == S_COLLECT) && !w_cancel_take;
        w_sel_take    = w_sel_live && w_sel_idx_ok && (r_credit >= w_price);
        w_sel_short   = w_sel_live && !w_sel_take;
        w_sum         = {1'b0, r_credit} + SUM_W'(coin_val);
        w_coin_take   = coin_valid && enable && (coin_val != 4'd0)
                        && ((r_state == S_IDLE) || (r_state == S_COLLECT))
                        && (w_sum <= MAX_SUM) && !w_cancel_take && !w_sel_take;
        // Any accepted coin or short selection this cycle restarts the idle window instead.
        w_timeout     = (r_state == S_COLLECT) && (r_idle_cnt == CNT_LAST)
                        && !w_cancel_take && !w_sel_take && !w_sel_short && !w_coin_take;
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt          = r_state;
        w_credit_nxt         = r_credit;
        w_change_nxt         = r_change;
        w_idle_cnt_nxt       = r_idle_cnt;
        w_coin_reject_nxt    = coin_valid && !w_coin_take;
        w_sel_short_nxt      = w_sel_short;
        w_dispense_valid_nxt = 1'b0;
        w_dispense_drink_nxt = '0;
        w_change_valid_nxt   = 1'b0;
        w_change_amt_nxt     = '0;

        case (r_state)
            S_IDLE: begin
                if (w_coin_take) begin
                    w_state_nxt    = S_COLLECT;
                    w_credit_nxt   = w_sum[CREDIT_W-1:0];
                    w_idle_cnt_nxt = '0;
                end
            end
            S_COLLECT: begin
                if (w_cancel_take || w_timeout) begin
                    w_state_nxt        = S_REFUND;
                    w_change_valid_nxt = 1'b1;
                    w_change_amt_nxt   = r_credit;
                    w_credit_nxt       = '0;
                    w_idle_cnt_nxt     = '0;
                end else if (w_sel_take) begin
                    w_state_nxt          = S_DISPENSE;
                    w_dispense_valid_nxt = 1'b1;
                    w_dispense_drink_nxt = sel_drink;
                    w_change_nxt         = r_credit - w_price;
                    w_credit_nxt         = '0;
                    w_idle_cnt_nxt       = '0;
                end else begin
                    if (w_coin_take) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                    end
                    if (w_coin_take || w_sel_short) begin
                        w_idle_cnt_nxt = '0;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + CNT_W'(1);
                    end
                end
            end
            S_DISPENSE: begin
                w_change_nxt = '0;
                if (r_change != '0) begin
                    w_state_nxt        = S_REFUND;
                    w_change_valid_nxt = 1'b1;
                    w_change_amt_nxt   = r_change;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REFUND: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_REFUND);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_credit         <= '0;
            r_change         <= '0;
            r_idle_cnt       <= '0;
            r_coin_reject    <= 1'b0;
            r_sel_short      <= 1'b0;
            r_dispense_valid <= 1'b0;
            r_dispense_drink <= '0;
            r_change_valid   <= 1'b0;
            r_change_amt     <= '0;
            r_busy           <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state          <= w_state_nxt;
            r_credit         <= w_credit_nxt;
            r_change         <= w_change_nxt;
            r_idle_cnt       <= w_idle_cnt_nxt;
            r_coin_reject    <= w_coin_reject_nxt;
            r_sel_short      <= w_sel_short_nxt;
            r_dispense_valid <= w_dispense_valid_nxt;
            r_dispense_drink <= w_dispense_drink_nxt;
            r_change_valid   <= w_change_valid_nxt;
            r_change_amt     <= w_change_amt_nxt;
            r_busy           <= w_busy_nxt;
        end
    end

    assign credit         = r_credit;
    assign coin_reject    = r_coin_reject;
    assign sel_short      = r_sel_short;
    assign dispense_valid = r_dispense_valid;
    assign dispense_drink = r_dispense_drink;
    assign change_valid   = r_change_valid;
    assign change_amt     = r_change_amt;
    assign busy           = r_busy;

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench for vending_controller: stimulus pushes expected pulse
// events (kind, cycle, value); a negedge monitor pops and compares them.
module tb_vending_controller;

    localparam int CW = 6;
    localparam int SW = 1;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          coin_valid;
    logic [3:0]    coin_val;
    logic          sel_valid;
    logic [SW-1:0] sel_drink;
    logic          cancel;
    logic [CW-1:0] credit;
    logic          coin_reject;
    logic          sel_short;
    logic          dispense_valid;
    logic [SW-1:0] dispense_drink;
    logic          change_valid;
    logic [CW-1:0] change_amt;
    logic          busy;

    vending_controller #(
        .NUM_DRINKS (2),
        .CREDIT_W   (CW),
        .PRICES     ({6'd9, 6'd7}),
        .MAX_CREDIT (50),
        .TIMEOUT    (8),
        .SEL_W      (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .coin_valid     (coin_valid),
        .coin_val       (coin_val),
        .sel_valid      (sel_valid),
        .sel_drink      (sel_drink),
        .cancel         (cancel),
        .credit         (credit),
        .coin_reject    (coin_reject),
        .sel_short      (sel_short),
        .dispense_valid (dispense_valid),
        .dispense_drink (dispense_drink),
        .change_valid   (change_valid),
        .change_amt     (change_amt),
        .busy           (busy)
    );

    typedef enum int {EV_REJECT, EV_SHORT, EV_DISP, EV_CHANGE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       val;
    } ev_t;

    ev_t sb[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int v, input int dly);
        ev_t e;
        e.kind = k;
        e.cyc  = cyc + dly;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input int v);
        ev_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected %s: value %0d at cycle %0d, none expected", k.name(), v, cyc);
        end else begin
            e = sb.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check({e.kind.name(), "_cycle"}, cyc, e.cyc);
            check({e.kind.name(), "_value"}, v, e.val);
        end
    endtask

    // Monitor: flags overdue expectations, then matches pulses in a fixed order.
    always @(negedge clk) begin
        ev_t m;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            m = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing %s: value %0d expected at cycle %0d, not seen by cycle %0d",
                     m.kind.name(), m.val, m.cyc, cyc);
        end
        if (coin_reject)    observe(EV_REJECT, 0);
        if (sel_short)      observe(EV_SHORT, 0);
        if (dispense_valid) observe(EV_DISP, int'(dispense_drink));
        if (change_valid)   observe(EV_CHANGE, int'(change_amt));
        if (!change_valid)   check("change_amt_idle", int'(change_amt), 0);
        if (!dispense_valid) check("dispense_drink_idle", int'(dispense_drink), 0);
    end

    task automatic do_cycle(input logic cv, input logic [3:0] val, input logic sv,
                            input logic [SW-1:0] sd, input logic cn);
        @(negedge clk);
        coin_valid = cv;
        coin_val   = val;
        sel_valid  = sv;
        sel_drink  = sd;
        cancel     = cn;
    endtask

    task automatic do_coin(input logic [3:0] v);
        do_cycle(1'b1, v, 1'b0, '0, 1'b0);
    endtask

    task automatic do_sel(input logic [SW-1:0] d);
        do_cycle(1'b0, 4'd0, 1'b1, d, 1'b0);
    endtask

    task automatic do_cancel();
        do_cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 4'd0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int t0;
        rst        = 1'b1;
        enable     = 1'b1;
        coin_valid = 1'b0;
        coin_val   = 4'd0;
        sel_valid  = 1'b0;
        sel_drink  = '0;
        cancel     = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_credit", int'(credit), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_dispense_valid", int'(dispense_valid), 0);
        check("reset_change_valid", int'(change_valid), 0);
        check("reset_coin_reject", int'(coin_reject), 0);
        check("reset_sel_short", int'(sel_short), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Tea with exact coins 5 + 2.
        do_coin(4'd5);
        do_coin(4'd2);
        check("tea_credit_5", int'(credit), 5);
        do_sel(1'b0);
        check("tea_credit_7", int'(credit), 7);
        expect_ev(EV_DISP, 0, 1);
        do_idle(1);
        check("tea_credit_dispense", int'(credit), 0);
        check("tea_busy_dispense", int'(busy), 1);
        do_idle(1);
        check("tea_busy_idle", int'(busy), 0);
        do_idle(1);

        // Coffee from 10 leaves Rs1 change two cycles after the selection.
        do_coin(4'd10);
        do_sel(1'b1);
        check("coffee_credit", int'(credit), 10);
        expect_ev(EV_DISP, 1, 1);
        expect_ev(EV_CHANGE, 1, 2);
        do_idle(1);
        check("coffee_busy_dispense", int'(busy), 1);
        do_idle(1);
        check("coffee_busy_refund", int'(busy), 1);
        do_idle(1);
        check("coffee_busy_idle", int'(busy), 0);

        // Short credit, then cancel refunds the full credit.
        do_coin(4'd5);
        do_sel(1'b1);
        expect_ev(EV_SHORT, 0, 1);
        do_idle(1);
        check("short_credit_kept", int'(credit), 5);
        do_cancel();
        expect_ev(EV_CHANGE, 5, 1);
        do_idle(1);
        check("cancel_credit_zero", int'(credit), 0);
        do_idle(1);

        // Overflow: 48 + 5 refused, 48 + 2 reaches the limit exactly.
        do_coin(4'd15);
        do_coin(4'd15);
        do_coin(4'd15);
        do_coin(4'd3);
        do_coin(4'd5);
        expect_ev(EV_REJECT, 0, 1);
        do_idle(1);
        check("overflow_credit_48", int'(credit), 48);
        do_coin(4'd2);
        do_idle(1);
        check("limit_credit_50", int'(credit), 50);
        do_cancel();
        expect_ev(EV_CHANGE, 50, 1);
        do_idle(2);

        // Coin and selection in the same cycle: selection wins, coin refused.
        do_coin(4'd10);
        do_cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        expect_ev(EV_REJECT, 0, 1);
        expect_ev(EV_DISP, 0, 1);
        expect_ev(EV_CHANGE, 3, 2);
        do_idle(3);

        // Enable low in IDLE refuses coins; zero-valued coin is refused too.
        do_coin(4'd2);
        enable = 1'b0;
        expect_ev(EV_REJECT, 0, 1);
        do_idle(1);
        enable = 1'b1;
        check("disabled_credit", int'(credit), 0);
        do_coin(4'd0);
        expect_ev(EV_REJECT, 0, 1);
        do_idle(1);

        // Selection in IDLE is ignored silently.
        do_sel(1'b0);
        do_idle(1);

        // Enable falls in COLLECT: selection ignored, credit kept, cancel still works.
        do_coin(4'd4);
        do_idle(1);
        do_sel(1'b0);
        enable = 1'b0;
        do_idle(1);
        check("disabled_credit_kept", int'(credit), 4);
        do_cancel();
        expect_ev(EV_CHANGE, 4, 1);
        do_idle(2);
        enable = 1'b1;

        // Idle timeout: refund 8 cycles after the credit update.
        do_coin(4'd2);
        t0 = cyc;
        expect_ev(EV_CHANGE, 2, 9);
        do_idle(4);
        check("timeout_credit_held", int'(credit), 2);
        do_idle(10);

        // Async reset during DISPENSE aborts the pending change.
        do_coin(4'd10);
        do_sel(1'b1);
        expect_ev(EV_DISP, 1, 1);
        @(negedge clk);
        sel_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_mid_dispense_valid", int'(dispense_valid), 0);
        check("rst_mid_dispense_drink", int'(dispense_drink), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_credit", int'(credit), 0);
        check("rst_mid_change_valid", int'(change_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_idle(4);
        check("post_reset_busy", int'(busy), 0);

        check("scoreboard_drained", sb.size(), 0);
        check("timeout_anchor", t0 + 9 <= cyc ? 1 : 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
